conv_stream_feeder: RTL

CONV_STREAM_FEEDER -- requirements
Module: conv_stream_feeder

---
 rtl/conv_stream_feeder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/conv_stream_feeder.sv
// Purpose: feeds NUM_CH conv engines in lockstep with a window of taps, an optional kernel, then a trigger beat.
// Latency: first beat is presented the cycle after a window is accepted; back-to-back windows stream with no bubble.
// Backpressure: beats hold stable while conv_ready is low; one pending window is buffered, win_ready = !pending_full.
// Ports: clk/rst (sync, active-high); win_valid/win_ready/win_data/send_weights (window in);
//        wr_en/wr_ready/wr_ch/wr_tap/wr_data (weight write); conv_valid/conv_ready/conv_idx/conv_data/conv_last (beats out); busy.
module conv_stream_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 2,
   parameter int TAPS       = 9,
   parameter int TRIG_IDX   = 9,
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         win_valid,
   output logic                         win_ready,
   input  logic [TAPS*DATA_WIDTH-1:0]   win_data,
   input  logic                         send_weights,
   input  logic                         wr_en,
   output logic                         wr_ready,
   input  logic [CW-1:0]                wr_ch,
   input  logic [TW-1:0]                wr_tap,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   output logic                         conv_valid,
   input  logic                         conv_ready,
   output logic [4:0]                   conv_idx,
   output logic [NUM_CH*DATA_WIDTH-1:0] conv_data,
   output logic                         conv_last,
   output logic                         busy
);

   typedef enum logic [1:0] {IDLE, WIN, WGT, TRIG} state_t;

   localparam logic [TW-1:0] KMAX = TW'(TAPS - 1);

   state_t                         state_q, state_d;
   logic [TW-1:0]                  k_q, k_d;
   logic [TAPS*DATA_WIDTH-1:0]     act_win_q, act_win_d;
   logic                           act_sw_q, act_sw_d;
   logic [TAPS*DATA_WIDTH-1:0]     pend_win_q, pend_win_d;
   logic                           pend_sw_q, pend_sw_d;
   logic                           pend_full_q, pend_full_d;
   logic [NUM_CH*TAPS*DATA_WIDTH-1:0] wgt_q;
   logic                           valid_q, valid_d;
   logic [4:0]                     idx_q, idx_d;
   logic [NUM_CH*DATA_WIDTH-1:0]   data_q, data_d;
   logic                           last_q, last_d;

   logic                           fire, win_acc, wr_acc, advance;
   logic [TAPS*DATA_WIDTH-1:0]     src_win;

   assign fire      = valid_q & conv_ready;
   assign win_ready = ~pend_full_q;
   assign win_acc   = win_valid & ~pend_full_q;
   assign wr_ready  = (state_q == IDLE) & ~pend_full_q;
   assign wr_acc    = wr_en & wr_ready;
   assign busy      = (state_q != IDLE);

   assign conv_valid = valid_q;
   assign conv_idx   = idx_q;
   assign conv_data  = data_q;
   assign conv_last  = last_q;

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      act_win_d   = act_win_q;
      act_sw_d    = act_sw_q;
      pend_win_d  = pend_win_q;
      pend_sw_d   = pend_sw_q;
      pend_full_d = pend_full_q;
      valid_d     = valid_q;
      idx_d       = idx_q;
      data_d      = data_q;
      last_d      = last_q;
      src_win     = act_win_q;
      advance     = 1'b0;

      if (state_q == IDLE) begin
         if (win_acc) begin
            act_win_d = win_data;
            act_sw_d  = send_weights;
            src_win   = win_data;
            state_d   = WIN;
            k_d       = '0;
            advance   = 1'b1;
         end
      end else begin
         // Any accept while streaming parks in pending; the trigger branch
         // below overrides this when the window can go straight to active.
         if (win_acc) begin
            pend_win_d  = win_data;
            pend_sw_d   = send_weights;
            pend_full_d = 1'b1;
         end
         if (fire) begin
            advance = 1'b1;
            case (state_q)
               WIN: begin
                  if (k_q == KMAX) begin
                     k_d     = '0;
                     state_d = act_sw_q ? WGT : TRIG;
                  end else begin
                     k_d = k_q + 1'b1;
                  end
               end
               WGT: begin
                  if (k_q == KMAX) begin
                     k_d     = '0;
                     state_d = TRIG;
                  end else begin
                     k_d = k_q + 1'b1;
                  end
               end
               default: begin
                  k_d = '0;
                  if (pend_full_q) begin
                     act_win_d   = pend_win_q;
                     act_sw_d    = pend_sw_q;
                     src_win     = pend_win_q;
                     pend_full_d = 1'b0;
                     state_d     = WIN;
                  end else if (win_acc) begin
                     act_win_d   = win_data;
                     act_sw_d    = send_weights;
                     src_win     = win_data;
                     pend_full_d = 1'b0;
                     state_d     = WIN;
                  end else begin
                     state_d = IDLE;
                  end
               end
            endcase
         end
      end

      // Beat registers only change when a new beat is due, so a stalled beat holds.
      if (advance) begin
         valid_d = (state_d != IDLE);
         last_d  = (state_d == TRIG);
         idx_d   = '0;
         data_d  = '0;
         case (state_d)
            WIN: begin
               idx_d = 5'(k_d);
               for (int c = 0; c < NUM_CH; c++)
                  data_d[c*DATA_WIDTH +: DATA_WIDTH] = src_win[int'(k_d)*DATA_WIDTH +: DATA_WIDTH];
            end
            WGT: begin
               idx_d = 5'(TAPS + int'(k_d));
               for (int c = 0; c < NUM_CH; c++)
                  data_d[c*DATA_WIDTH +: DATA_WIDTH] = wgt_q[(c*TAPS + int'(k_d))*DATA_WIDTH +: DATA_WIDTH];
            end
            TRIG:    idx_d = 5'(TRIG_IDX);
            default: idx_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         act_win_q   <= '0;
         act_sw_q    <= 1'b0;
         pend_win_q  <= '0;
         pend_sw_q   <= 1'b0;
         pend_full_q <= 1'b0;
         wgt_q       <= '0;
         valid_q     <= 1'b0;
         idx_q       <= '0;
         data_q      <= '0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         act_win_q   <= act_win_d;
         act_sw_q    <= act_sw_d;
         pend_win_q  <= pend_win_d;
         pend_sw_q   <= pend_sw_d;
         pend_full_q <= pend_full_d;
         valid_q     <= valid_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         last_q      <= last_d;
         // Writes to a channel/tap that does not exist are acknowledged but dropped.
         if (wr_acc && (int'(wr_ch) < NUM_CH) && (int'(wr_tap) < TAPS))
            wgt_q[(int'(wr_ch)*TAPS + int'(wr_tap))*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
      end
   end

endmodule
